// File: rtl/alu_pkg.sv
// Shared decode constants, instruction-field positions and FSM encoding
// for the single-issue ALU front end.
package alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_CAPTURE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        C_RTYPE   = 2'd0,
        C_ITYPE   = 2'd1,
        C_BRANCH  = 2'd2,
        C_ILLEGAL = 2'd3
    } iclass_e;

    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNC_LSB  = 0;
    localparam int IMM_LSB   = 0;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    localparam logic [5:0] FUNC_ADD  = 6'b100000;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
    localparam logic [5:0] FUNC_XOR  = 6'b100110;

    function automatic iclass_e classify(input logic [5:0] opc);
        case (opc)
            OPC_RTYPE:                 return C_RTYPE;
            OPC_ADDI, OPC_SLTI, OPC_ANDI,
            OPC_ORI, OPC_XORI, OPC_LUI: return C_ITYPE;
            OPC_BEQ, OPC_BNE:          return C_BRANCH;
            default:                   return C_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, register 0 hard-wired to zero, async active-low clear.
module alu_regfile #(
    parameter int REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem_q [REG_COUNT];
    logic [31:0] mem_d [REG_COUNT];

    always_comb begin
        mem_d = mem_q;
        if (we && waddr != 5'd0 && 32'(waddr) < REG_COUNT) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = (raddr_a != 5'd0 && 32'(raddr_a) < REG_COUNT) ? mem_q[raddr_a] : '0;
    assign rdata_b = (raddr_b != 5'd0 && 32'(raddr_b) < REG_COUNT) ? mem_q[raddr_b] : '0;

endmodule

// File: rtl/alu_issue_unit.sv
// Single-issue front end: accepts one instruction, presents operands to an
// external ALU, captures its result and retires it in four cycles.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      INSTR,
    input  logic             INSTR_VALID,
    output logic             INSTR_READY,
    output logic [5:0]       OPCODE,
    output logic [31:0]      RS_VAL,
    output logic [31:0]      RT_VAL,
    output logic [4:0]       SHAMT,
    output logic [5:0]       FUNC,
    output logic [15:0]      RAW_VAL,
    input  logic [31:0]      RESULT,
    input  logic             SIG_B,
    output logic             WB_VALID,
    output logic [4:0]       WB_ADDR,
    output logic [31:0]      WB_DATA,
    output logic             BRANCH_TAKEN,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] INSTR_CNT
);

    state_e            state_q,    state_d;
    logic [31:0]       instr_q,    instr_d;
    logic [5:0]        opcode_q,   opcode_d;
    logic [31:0]       rs_val_q,   rs_val_d;
    logic [31:0]       rt_val_q,   rt_val_d;
    logic [4:0]        shamt_q,    shamt_d;
    logic [5:0]        func_q,     func_d;
    logic [15:0]       raw_val_q,  raw_val_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_addr_q,  wb_addr_d;
    logic [31:0]       wb_data_q,  wb_data_d;
    logic              branch_q,   branch_d;
    logic              illegal_q,  illegal_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic [5:0]  f_opc;
    logic [4:0]  f_rs, f_rt, f_rd, f_shamt, dest;
    logic [5:0]  f_func;
    logic [15:0] f_imm;
    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic        rf_we, writes_reg;
    iclass_e     cls;

    assign f_opc   = instr_q[OPC_LSB   +: 6];
    assign f_rs    = instr_q[RS_LSB    +: 5];
    assign f_rt    = instr_q[RT_LSB    +: 5];
    assign f_rd    = instr_q[RD_LSB    +: 5];
    assign f_shamt = instr_q[SHAMT_LSB +: 5];
    assign f_func  = instr_q[FUNC_LSB  +: 6];
    assign f_imm   = instr_q[IMM_LSB   +: 16];

    assign cls        = classify(f_opc);
    assign dest       = (cls == C_RTYPE) ? f_rd : f_rt;
    assign writes_reg = (cls == C_RTYPE || cls == C_ITYPE) && dest != 5'd0;

    alu_regfile #(.REG_COUNT(REG_COUNT)) u_regfile (
        .clk     (CLK),
        .rst_n   (RST_N),
        .raddr_a (f_rs),
        .raddr_b (f_rt),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b),
        .we      (rf_we),
        .waddr   (wb_addr_q),
        .wdata   (wb_data_q)
    );

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        opcode_d   = opcode_q;
        rs_val_d   = rs_val_q;
        rt_val_d   = rt_val_q;
        shamt_d    = shamt_q;
        func_d     = func_q;
        raw_val_d  = raw_val_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        branch_d   = 1'b0;
        illegal_d  = 1'b0;
        rf_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (INSTR_VALID) begin
                    instr_d = INSTR;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                opcode_d  = f_opc;
                rs_val_d  = rf_rdata_a;
                rt_val_d  = rf_rdata_b;
                shamt_d   = f_shamt;
                func_d    = f_func;
                raw_val_d = f_imm;
                state_d   = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Result and branch condition are sampled here; the status
                // pulses are therefore visible throughout WRITEBACK.
                wb_addr_d  = dest;
                wb_data_d  = RESULT;
                wb_valid_d = writes_reg;
                branch_d   = (cls == C_BRANCH) && SIG_B;
                illegal_d  = (cls == C_ILLEGAL);
                state_d    = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                rf_we   = writes_reg;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            opcode_q   <= '0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            shamt_q    <= '0;
            func_q     <= '0;
            raw_val_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            branch_q   <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            opcode_q   <= opcode_d;
            rs_val_q   <= rs_val_d;
            rt_val_q   <= rt_val_d;
            shamt_q    <= shamt_d;
            func_q     <= func_d;
            raw_val_q  <= raw_val_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            branch_q   <= branch_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
        end
    end

    // Gated by RST_N so the handshake is closed while reset is held.
    assign INSTR_READY  = (state_q == S_IDLE) && RST_N;
    assign OPCODE       = opcode_q;
    assign RS_VAL       = rs_val_q;
    assign RT_VAL       = rt_val_q;
    assign SHAMT        = shamt_q;
    assign FUNC         = func_q;
    assign RAW_VAL      = raw_val_q;
    assign WB_VALID     = wb_valid_q;
    assign WB_ADDR      = wb_addr_q;
    assign WB_DATA      = wb_data_q;
    assign BRANCH_TAKEN = branch_q;
    assign ILLEGAL      = illegal_q;
    assign INSTR_CNT    = cnt_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a small behavioural ALU attached.
module tb_alu_issue_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] INSTR = '0;
    logic        INSTR_VALID = 1'b0;
    logic        INSTR_READY;
    logic [5:0]  OPCODE;
    logic [31:0] RS_VAL, RT_VAL;
    logic [4:0]  SHAMT;
    logic [5:0]  FUNC;
    logic [15:0] RAW_VAL;
    logic [31:0] RESULT;
    logic        SIG_B;
    logic        WB_VALID;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA;
    logic        BRANCH_TAKEN, ILLEGAL;
    logic [15:0] INSTR_CNT;

    int checks = 0;
    int failures = 0;

    logic [5:0]  o_op, o_fn;
    logic [31:0] o_rs, o_rt, o_wd;
    logic [15:0] o_raw;
    logic        o_wv, o_br, o_ill, o_post;
    logic [4:0]  o_wa;
    logic [15:0] o_cnt;

    alu_issue_unit #(.REG_COUNT(32), .CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .OPCODE(OPCODE), .RS_VAL(RS_VAL), .RT_VAL(RT_VAL),
        .SHAMT(SHAMT), .FUNC(FUNC), .RAW_VAL(RAW_VAL), .RESULT(RESULT), .SIG_B(SIG_B),
        .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .BRANCH_TAKEN(BRANCH_TAKEN), .ILLEGAL(ILLEGAL), .INSTR_CNT(INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    // External ALU stand-in
    always_comb begin
        RESULT = '0;
        SIG_B  = 1'b0;
        case (OPCODE)
            6'b000000: begin
                case (FUNC)
                    6'b100110: RESULT = RS_VAL ^ RT_VAL;
                    6'b100101: RESULT = RS_VAL | RT_VAL;
                    default:   RESULT = RS_VAL + RT_VAL;
                endcase
            end
            6'b001101: RESULT = RS_VAL | {16'h0, RAW_VAL};
            6'b001000: RESULT = RS_VAL + {{16{RAW_VAL[15]}}, RAW_VAL};
            6'b000100: SIG_B = (RS_VAL == RT_VAL);
            6'b000101: SIG_B = (RS_VAL != RT_VAL);
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with the DUT idle; leaves it idle.
    task automatic run_instr(input logic [31:0] ins);
        int waitc = 0;
        INSTR = ins;
        INSTR_VALID = 1'b1;
        while (!INSTR_READY && waitc < 8) begin
            @(posedge CLK); #1;
            waitc++;
        end
        if (!INSTR_READY) begin
            chk("ready_timeout", 32'(INSTR_READY), 32'd1);
            INSTR_VALID = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        INSTR_VALID = 1'b0;
        INSTR = 32'hFC00_0000;
        @(posedge CLK); #1;
        o_op = OPCODE; o_rs = RS_VAL; o_rt = RT_VAL; o_raw = RAW_VAL; o_fn = FUNC;
        @(posedge CLK); #1;
        o_wv = WB_VALID; o_wa = WB_ADDR; o_wd = WB_DATA; o_br = BRANCH_TAKEN; o_ill = ILLEGAL;
        @(posedge CLK); #1;
        o_post = WB_VALID | BRANCH_TAKEN | ILLEGAL;
        o_cnt = INSTR_CNT;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, ill_seen, wv_seen;

        #12;
        chk("rst_ready",  32'(INSTR_READY), 32'd0);
        chk("rst_wbv",    32'(WB_VALID),    32'd0);
        chk("rst_opcode", 32'(OPCODE),      32'd0);
        chk("rst_cnt",    32'(INSTR_CNT),   32'd0);
        #10 RST_N = 1'b1;
        #1;
        chk("rel_ready",  32'(INSTR_READY), 32'd1);
        @(posedge CLK); #1;

        // ori $1,$0,15
        run_instr(32'h3401_000F);
        chk("ori1_op",   32'(o_op),  32'h0D);
        chk("ori1_rs",   o_rs,       32'd0);
        chk("ori1_raw",  32'(o_raw), 32'd15);
        chk("ori1_wv",   32'(o_wv),  32'd1);
        chk("ori1_wa",   32'(o_wa),  32'd1);
        chk("ori1_wd",   o_wd,       32'd15);
        chk("ori1_post", 32'(o_post), 32'd0);
        chk("ori1_cnt",  32'(o_cnt), 32'd1);

        // ori $2,$0,12 ; xor $3,$1,$2
        run_instr(32'h3402_000C);
        chk("ori2_wd",  o_wd, 32'd12);
        run_instr(32'h0022_1826);
        chk("xor3_rs",  o_rs,       32'd15);
        chk("xor3_rt",  o_rt,       32'd12);
        chk("xor3_fn",  32'(o_fn),  32'h26);
        chk("xor3_wv",  32'(o_wv),  32'd1);
        chk("xor3_wa",  32'(o_wa),  32'd3);
        chk("xor3_wd",  o_wd,       32'd3);
        chk("xor3_cnt", 32'(o_cnt), 32'd3);

        // ori $0,$0,7 must not write; xor $4,$0,$1
        run_instr(32'h3400_0007);
        chk("ori0_wv",  32'(o_wv),  32'd0);
        chk("ori0_cnt", 32'(o_cnt), 32'd4);
        run_instr(32'h0001_2026);
        chk("xor4_rs",  o_rs,       32'd0);
        chk("xor4_wa",  32'(o_wa),  32'd4);
        chk("xor4_wd",  o_wd,       32'd15);

        // beq $1,$1 taken
        run_instr(32'h1021_0000);
        chk("beq_br",   32'(o_br),  32'd1);
        chk("beq_wv",   32'(o_wv),  32'd0);
        chk("beq_post", 32'(o_post), 32'd0);
        chk("beq_cnt",  32'(o_cnt), 32'd6);

        // illegal opcode 111111
        run_instr(32'hFC00_0000);
        chk("ill_ill",  32'(o_ill), 32'd1);
        chk("ill_wv",   32'(o_wv),  32'd0);
        chk("ill_br",   32'(o_br),  32'd0);
        chk("ill_post", 32'(o_post), 32'd0);
        chk("ill_cnt",  32'(o_cnt), 32'd7);

        // beq $1,$2 not taken
        run_instr(32'h1022_0000);
        chk("beqn_br",  32'(o_br),  32'd0);
        chk("beqn_cnt", 32'(o_cnt), 32'd8);

        // INSTR_VALID held high over three instructions; junk while busy
        acc = 0; ill_seen = 0;
        INSTR_VALID = 1'b1;
        for (int i = 0; i < 12; i++) begin
            INSTR = INSTR_READY ? (32'h3405_0000 | 32'(i / 4 + 1)) : 32'hFC00_0000;
            chk("stream_ready", 32'(INSTR_READY), 32'((i % 4) == 0));
            if (INSTR_READY) acc++;
            if (ILLEGAL) ill_seen++;
            @(posedge CLK); #1;
        end
        INSTR_VALID = 1'b0;
        chk("stream_acc", 32'(acc),       32'd3);
        chk("stream_ill", 32'(ill_seen),  32'd0);
        chk("stream_cnt", 32'(INSTR_CNT), 32'd11);
        run_instr(32'h00A0_3026);
        chk("xor6_wd",  o_wd,       32'd3);
        chk("xor6_cnt", 32'(o_cnt), 32'd12);

        // Reset in CAPTURE: ori $7,$0,9 aborted
        INSTR = 32'h3407_0009;
        INSTR_VALID = 1'b1;
        @(posedge CLK); #1;
        INSTR_VALID = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        chk("arst_cnt",   32'(INSTR_CNT), 32'd0);
        chk("arst_ready", 32'(INSTR_READY), 32'd0);
        chk("arst_wbv",   32'(WB_VALID),  32'd0);
        chk("arst_rs",    RS_VAL,         32'd0);
        @(posedge CLK); #2;
        RST_N = 1'b1;
        #1;
        chk("arel_ready", 32'(INSTR_READY), 32'd1);
        wv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            if (WB_VALID) wv_seen++;
        end
        chk("arst_no_wb",  32'(wv_seen),   32'd0);
        chk("arst_cnt2",   32'(INSTR_CNT), 32'd0);
        run_instr(32'h0022_4026);
        chk("post_rs",  o_rs,       32'd0);
        chk("post_rt",  o_rt,       32'd0);
        chk("post_wv",  32'(o_wv),  32'd1);
        chk("post_wa",  32'(o_wa),  32'd8);
        chk("post_wd",  o_wd,       32'd0);
        chk("post_cnt", 32'(o_cnt), 32'd1);
        run_instr(32'h00E5_4826);
        chk("post7_rs", o_rs, 32'd0);
        chk("post5_rt", o_rt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have parameter REG_COUNT, default 32, number of architectural registers (register 0 reads as zero).
REQ-002 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports named CLK and RST_N.
REQ-004 SHALL have ports: CLK in 1 clock; RST_N in 1 async active-low reset.
REQ-005 SHALL have ports: INSTR in 32 instruction word; INSTR_VALID in 1 word offered; INSTR_READY out 1 word accepted when both high.
REQ-006 SHALL have ALU-side ports: OPCODE out 6; RS_VAL out 32; RT_VAL out 32; SHAMT out 5; FUNC out 6; RAW_VAL out 16; RESULT in 32; SIG_B in 1 branch condition.
REQ-007 SHALL have status ports: WB_VALID out 1 write-back pulse; WB_ADDR out 5; WB_DATA out 32; BRANCH_TAKEN out 1 pulse; ILLEGAL out 1 pulse; INSTR_CNT out CNT_W retired count.

Function
REQ-008 SHALL decode INSTR fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], func[5:0], imm[15:0].
REQ-009 SHALL run FSM IDLE -> ISSUE -> CAPTURE -> WRITEBACK -> IDLE, one instruction in flight, 4 cycles per instruction.
REQ-010 SHALL assert INSTR_READY only in IDLE; acceptance (INSTR_VALID & INSTR_READY) latches INSTR and moves to ISSUE.
REQ-011 SHALL, in ISSUE, register OPCODE/SHAMT/FUNC/RAW_VAL from latched fields and RS_VAL/RT_VAL from register file reads of rs/rt; these outputs hold stable through CAPTURE and WRITEBACK until next acceptance.
REQ-012 SHALL, in CAPTURE, sample RESULT and SIG_B into internal registers.
REQ-013 SHALL classify: opcode 000000 -> write-back to rd; opcodes 001000, 001010, 001100, 001101, 001110, 001111 -> write-back to rt; 000100, 000101 -> branch, no write-back; any other -> illegal, no write-back.
REQ-014 SHALL, in WRITEBACK, for write-back classes with destination != 0, write captured RESULT to register file and pulse WB_VALID one cycle with WB_ADDR/WB_DATA valid that cycle.
REQ-015 SHALL suppress both register write and WB_VALID when destination is 0; register 0 always reads 0.
REQ-016 SHALL pulse BRANCH_TAKEN one cycle in WRITEBACK for branch class when captured SIG_B=1; never otherwise.
REQ-017 SHALL pulse ILLEGAL one cycle in WRITEBACK for illegal class.
REQ-018 SHALL increment INSTR_CNT by 1 in WRITEBACK for every instruction (including illegal), wrapping modulo 2^CNT_W.
REQ-019 SHALL read updated register values on the instruction immediately following a write-back (write completes before next ISSUE; no forwarding needed).
REQ-020 SHALL ignore INSTR changes while not in IDLE; INSTR_VALID held high during busy is accepted exactly once, on return to IDLE.

Reset
REQ-021 SHALL, on RST_N low, immediately force state IDLE, all outputs 0 (INSTR_READY 0 during reset, 1 in first cycle after release), all registers and INSTR_CNT 0.
REQ-022 SHALL abort any in-flight instruction on reset with no write-back, branch or illegal pulse and no count increment.

Structure
REQ-023 SHALL place opcode/func constants, field bit positions, and FSM state encoding in shared package alu_pkg.
REQ-024 SHALL implement the register file as sub-module alu_regfile: REG_COUNT x 32, two combinational read ports, one synchronous write port, async active-low clear.

Verification
REQ-025 SHALL test: reset, ori $1,$0,15 (0x3401000F) -> ISSUE shows OPCODE=001101 RS_VAL=0 RAW_VAL=15; WB_VALID with WB_ADDR=1 WB_DATA=15 on 4th cycle after acceptance.
REQ-026 SHALL test: ori $2,$0,12 then xor $3,$1,$2 (func 100110) -> RS_VAL=15 RT_VAL=12 FUNC=100110; WB_ADDR=3 WB_DATA=3; INSTR_CNT=3.
REQ-027 SHALL test: ori $0,$0,7 -> no WB_VALID; following xor $4,$0,$1 sees RS_VAL=0, WB_DATA=15.
REQ-028 SHALL test: beq $1,$1 with ALU SIG_B=1 -> BRANCH_TAKEN one-cycle pulse, no WB_VALID; opcode 111111 -> ILLEGAL pulse, count increments.
REQ-029 SHALL test: INSTR_VALID held high continuously over 3 instructions -> exactly one acceptance per 4 cycles, INSTR_READY low in ISSUE/CAPTURE/WRITEBACK.
REQ-030 SHALL test: RST_N low during CAPTURE -> no WB_VALID, INSTR_CNT=0, all registers read 0 afterwards.
